// File: rtl/pe_shell_axis.sv
`default_nettype none
// ============================================================================
// Module   : pe_shell_fifo
// Purpose  : First-word-fall-through FIFO used for every channel of the
//            stream shell. The head word is visible on o_dout whenever
//            o_empty is low. A push into a full FIFO is ignored; the caller
//            decides what that means. i_flush empties the FIFO synchronously
//            and overrides any push or pop on the same edge.
// Ports    : CLK, RST_N (async active-low), i_flush, i_push/i_din,
//            i_pop, o_dout, o_empty, o_full, o_count (log2(DEPTH)+1 bits)
// Revision : 1.0 - initial release
// ============================================================================
module pe_shell_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 512
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_depth);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // Fullness is judged before the pop of the same edge, so a push into a
  // full FIFO is dropped even when a word leaves at that moment.
  assign w_push = i_push & ~o_full  & ~i_flush;
  assign w_pop  = i_pop  & ~o_empty & ~i_flush;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// ============================================================================
// Module   : pe_shell_axis
// Purpose  : Stream shell between router-side valid/back-pressure channels
//            and an externally instantiated HLS core with AXI-Stream ports.
//            NIN input and NOUT output channels, each buffered in a FWFT
//            FIFO with an almost-full threshold. Adds a soft flush on PE_RST,
//            sticky per-input overflow flags and per-output word counters.
// Ports    : CLK, SYS_RST_N (async active-low), PE_RST (sync flush)
//            D/D_VALID/D_BP           router input channels
//            Q/Q_VALID/Q_BP           router output channels
//            CORE_IN_T*               FIFO heads toward the core
//            CORE_OUT_T*              core results into the shell
//            CORE_RST_N               core reset, one edge behind PE_RST
//            OVF                      sticky input-overflow flags
//            OUT_WORDS                32-bit delivered-word count per output
// Revision : 1.0 - initial release
// ============================================================================
module pe_shell_axis #(
  parameter int W     = 64,
  parameter int NIN   = 2,
  parameter int NOUT  = 2,
  parameter int DEPTH = 512,
  parameter int AFULL = DEPTH - 8
) (
  input  logic              CLK,
  input  logic              SYS_RST_N,
  input  logic              PE_RST,
  input  logic [NIN*W-1:0]  D,
  input  logic [NIN-1:0]    D_VALID,
  output logic [NIN-1:0]    D_BP,
  output logic [NOUT*W-1:0] Q,
  output logic [NOUT-1:0]   Q_VALID,
  input  logic [NOUT-1:0]   Q_BP,
  output logic [NIN*W-1:0]  CORE_IN_TDATA,
  output logic [NIN-1:0]    CORE_IN_TVALID,
  input  logic [NIN-1:0]    CORE_IN_TREADY,
  input  logic [NOUT*W-1:0] CORE_OUT_TDATA,
  input  logic [NOUT-1:0]   CORE_OUT_TVALID,
  output logic [NOUT-1:0]   CORE_OUT_TREADY,
  output logic              CORE_RST_N,
  output logic [NIN-1:0]    OVF,
  output logic [NOUT*32-1:0] OUT_WORDS
);

  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam logic [c_cw-1:0] c_afull = c_cw'(AFULL);

  logic [NIN*W-1:0] r_dr;
  logic [NIN-1:0]   r_dvr;
  logic [NIN-1:0]   r_ovf;
  logic             r_core_rst_n;
  logic [31:0]      r_out_words [NOUT];

  logic [NIN-1:0]   w_in_full;
  logic [NIN-1:0]   w_in_empty;
  logic [c_cw-1:0]  w_in_count [NIN];
  logic [NOUT-1:0]  w_out_full;
  logic [NOUT-1:0]  w_out_empty;
  logic [c_cw-1:0]  w_out_count [NOUT];
  logic [NOUT-1:0]  w_q_valid;

  // Input retiming stage. A flush discards the word currently held in DVR.
  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_dr  <= '0;
      r_dvr <= '0;
    end else begin
      r_dr  <= D;
      r_dvr <= PE_RST ? '0 : D_VALID;
    end
  end

  // Sticky overflow: a retimed strobe that finds its FIFO full.
  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N)  r_ovf <= '0;
    else if (PE_RST) r_ovf <= '0;
    else             r_ovf <= r_ovf | (r_dvr & w_in_full);
  end

  // Core reset follows PE_RST one edge late and is held low by system reset.
  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) r_core_rst_n <= 1'b0;
    else            r_core_rst_n <= ~PE_RST;
  end

  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      for (int j = 0; j < NOUT; j++) r_out_words[j] <= '0;
    end else if (PE_RST) begin
      for (int j = 0; j < NOUT; j++) r_out_words[j] <= '0;
    end else begin
      for (int j = 0; j < NOUT; j++)
        if (w_q_valid[j]) r_out_words[j] <= r_out_words[j] + 32'd1;
    end
  end

  assign OVF        = r_ovf;
  assign CORE_RST_N = r_core_rst_n;
  assign Q_VALID    = w_q_valid;

  generate
    for (genvar i = 0; i < NIN; i++) begin : g_in
      pe_shell_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST_N   (SYS_RST_N),
        .i_flush (PE_RST),
        .i_push  (r_dvr[i]),
        .i_din   (r_dr[i*W +: W]),
        .i_pop   (CORE_IN_TVALID[i] & CORE_IN_TREADY[i]),
        .o_dout  (CORE_IN_TDATA[i*W +: W]),
        .o_empty (w_in_empty[i]),
        .o_full  (w_in_full[i]),
        .o_count (w_in_count[i])
      );
      assign CORE_IN_TVALID[i] = ~w_in_empty[i];
      // Combinational on the count so upstream sees pressure immediately;
      // the DEPTH-AFULL words of slack cover the upstream reaction delay.
      assign D_BP[i] = ~SYS_RST_N | PE_RST | (w_in_count[i] >= c_afull);
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_out
      pe_shell_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST_N   (SYS_RST_N),
        .i_flush (PE_RST),
        .i_push  (CORE_OUT_TVALID[j] & CORE_OUT_TREADY[j]),
        .i_din   (CORE_OUT_TDATA[j*W +: W]),
        .i_pop   (w_q_valid[j]),
        .o_dout  (Q[j*W +: W]),
        .o_empty (w_out_empty[j]),
        .o_full  (w_out_full[j]),
        .o_count (w_out_count[j])
      );
      // The almost-full term already keeps the FIFO from filling; the full
      // term only makes that guarantee local to this expression.
      assign CORE_OUT_TREADY[j] = ~PE_RST & r_core_rst_n & ~w_out_full[j] &
                                  (w_out_count[j] < c_afull);
      // Downstream has no ready: a presented word is consumed that cycle.
      assign w_q_valid[j] = ~w_out_empty[j] & ~Q_BP[j];
      assign OUT_WORDS[j*32 +: 32] = r_out_words[j];
    end
  endgenerate

endmodule
`default_nettype wire
